// File: rtl/prirv32_pkg.sv
// Shared types for the PRIRV32 memory arbiter: access sizes, FSM states and
// the latched request attributes.
package prirv32_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    BUS_REQ,
    BUS_RESP,
    ERR
  } state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } owner_e;

  typedef struct packed {
    owner_e      owner;
    logic        we;
    size_e       size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_attr_t;

  // True when the access cannot be issued on the word bus.
  function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = addr_lo[0];
      SIZE_WORD: is_misaligned = (addr_lo != 2'b00);
      default:   is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/prirv32_lane_align.sv
// Byte-lane steering: byte enables, store-data replication and load
// extract/extend for a single word-bus access.
module prirv32_lane_align
  import prirv32_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    shifted = rdata_i >> {addr_lo_i, 3'b000};
    case (size_i)
      SIZE_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = uns_i ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = uns_i ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end
      SIZE_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/prirv32_mem_arbiter.sv
// Arbitrates the IFU and LSU onto one word-wide memory bus with a single
// outstanding transaction and starvation protection for instruction fetch.
module prirv32_mem_arbiter
  import prirv32_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [1:0]  ls_size_i,
  input  logic        ls_unsigned_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        ls_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q;
  req_attr_t   attr_q;
  logic [3:0]  starve_q;
  logic        if_rvalid_q, ls_rvalid_q, ls_err_q;
  logic [31:0] if_rdata_q, ls_rdata_q;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;
  size_e       ls_size;

  assign ls_size = size_e'(ls_size_i);

  // Grants are decided in the IDLE cycle itself; a pending reset suppresses them.
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (state_q == IDLE && !rst_i) begin
      if (if_req_i && (!ls_req_i || starve_q == LIMIT)) if_gnt_o = 1'b1;
      else if (ls_req_i)                                  ls_gnt_o = 1'b1;
    end
  end

  prirv32_lane_align u_lane (
    .size_i    (attr_q.size),
    .addr_lo_i (attr_q.addr[1:0]),
    .uns_i     (attr_q.uns),
    .wdata_i   (attr_q.wdata),
    .rdata_i   (mem_rdata_i),
    .be_o      (lane_be),
    .wdata_o   (lane_wdata),
    .rdata_o   (lane_rdata)
  );

  assign mem_req_o   = (state_q == BUS_REQ);
  assign mem_we_o    = mem_req_o & attr_q.we;
  assign mem_addr_o  = mem_req_o ? {attr_q.addr[31:2], 2'b00} : '0;
  assign mem_be_o    = mem_req_o ? lane_be : '0;
  assign mem_wdata_o = mem_we_o ? lane_wdata : '0;

  assign if_rvalid_o = if_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign ls_err_o    = ls_err_q;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      attr_q      <= '0;
      starve_q    <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      ls_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;

      if (if_gnt_o) starve_q <= '0;
      else if (ls_gnt_o && if_req_i && starve_q != LIMIT) starve_q <= starve_q + 4'd1;

      case (state_q)
        IDLE: begin
          if (if_gnt_o) begin
            attr_q.owner <= OWN_IFU;
            attr_q.we    <= 1'b0;
            attr_q.size  <= SIZE_WORD;
            attr_q.uns   <= 1'b1;
            attr_q.addr  <= if_addr_i;
            attr_q.wdata <= '0;
            state_q      <= BUS_REQ;
          end else if (ls_gnt_o) begin
            attr_q.owner <= OWN_LSU;
            attr_q.we    <= ls_we_i;
            attr_q.size  <= ls_size;
            attr_q.uns   <= ls_unsigned_i;
            attr_q.addr  <= ls_addr_i;
            attr_q.wdata <= ls_wdata_i;
            // Faulting accesses never reach the bus; the error completes next cycle.
            if (is_misaligned(ls_size, ls_addr_i[1:0])) begin
              state_q     <= ERR;
              ls_rvalid_q <= 1'b1;
              ls_err_q    <= 1'b1;
            end else begin
              state_q <= BUS_REQ;
            end
          end
        end
        BUS_REQ: if (mem_gnt_i) state_q <= BUS_RESP;
        BUS_RESP: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
            if (attr_q.owner == OWN_IFU) begin
              if_rvalid_q <= 1'b1;
              if_rdata_q  <= mem_rdata_i;
            end else begin
              ls_rvalid_q <= 1'b1;
              ls_rdata_q  <= attr_q.we ? 32'h0 : lane_rdata;
            end
          end
        end
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prirv32_mem_arbiter.sv
// Scoreboard bench for prirv32_mem_arbiter: directed accesses with
// hand-computed bus attributes and responses, starvation order and mid-flight reset.
module tb_prirv32_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i = 1'b0, ls_we_i = 1'b0, ls_unsigned_i = 1'b0;
  logic [1:0]  ls_size_i = 2'b00;
  logic [31:0] ls_addr_i = '0, ls_wdata_i = '0;
  logic        ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  typedef struct {
    logic        is_ifu;
    logic [31:0] data;
    logic        err;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } bus_t;

  resp_t exp_q[$];
  bus_t  bus_q[$];
  int    passed = 0;
  int    total  = 0;
  logic  auto_bus = 1'b1;

  always #5 clk = ~clk;

  prirv32_mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_size_i(ls_size_i),
    .ls_unsigned_i(ls_unsigned_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .ls_err_o(ls_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic any_output();
    return |{if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
             ls_err_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o};
  endfunction

  function automatic void exp_ls(input logic [31:0] data, input logic err);
    resp_t r;
    r.is_ifu = 1'b0; r.data = data; r.err = err;
    exp_q.push_back(r);
  endfunction

  function automatic void exp_if(input logic [31:0] data);
    resp_t r;
    r.is_ifu = 1'b1; r.data = data; r.err = 1'b0;
    exp_q.push_back(r);
  endfunction

  function automatic void exp_bus(input logic [31:0] addr, input logic [3:0] be, input logic we,
                                  input logic [31:0] wdata, input logic [31:0] rdata);
    bus_t b;
    b.addr = addr; b.be = be; b.we = we; b.wdata = wdata; b.rdata = rdata;
    bus_q.push_back(b);
  endfunction

  // Bus slave: checks each request against the expected queue, then answers.
  initial begin
    bus_t b;
    forever begin
      @(negedge clk);
      if (!mem_req_o && !rst_i)
        check("mem_idle_zero", {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o}, 0);
      if (auto_bus && mem_req_o) begin
        if (bus_q.size() == 0) begin
          check("unexpected_bus_req", 1, 0);
          b = '{addr: 0, be: 0, we: 0, wdata: 0, rdata: 0};
        end else begin
          b = bus_q.pop_front();
          check("mem_addr", mem_addr_o, b.addr);
          check("mem_be", mem_be_o, b.be);
          check("mem_we", mem_we_o, b.we);
          if (b.we) check("mem_wdata", mem_wdata_o, b.wdata);
        end
        mem_gnt_i = 1'b1;
        @(negedge clk);
        mem_gnt_i = 1'b0;
        check("mem_req_dropped", mem_req_o, 0);
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = b.rdata;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever either port completes.
  initial begin
    resp_t r;
    forever begin
      @(negedge clk);
      if (if_rvalid_o || ls_rvalid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rvalid", {if_rvalid_o, ls_rvalid_o}, 0);
        end else begin
          r = exp_q.pop_front();
          check("rv_owner_ifu", {if_rvalid_o, ls_rvalid_o}, {r.is_ifu, !r.is_ifu});
          check("rv_data", r.is_ifu ? if_rdata_o : ls_rdata_o, r.data);
          check("rv_err", ls_err_o, r.err);
        end
      end
    end
  end

  task automatic drain();
    bit done = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && bus_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) check("drain_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic wait_gnt(input logic ifu, input string name);
    bit got = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ifu ? if_gnt_o : ls_gnt_o) begin
        got = 1'b1;
        break;
      end
    end
    check(name, got, 1);
  endtask

  task automatic ls_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    ls_req_i = 1'b1; ls_we_i = we; ls_size_i = size; ls_unsigned_i = uns;
    ls_addr_i = addr; ls_wdata_i = wdata;
    wait_gnt(1'b0, "ls_gnt");
    @(posedge clk); #1;
    ls_req_i = 1'b0;
    drain();
  endtask

  task automatic if_op(input logic [31:0] addr);
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = addr;
    wait_gnt(1'b1, "if_gnt");
    @(posedge clk); #1;
    if_req_i = 1'b0;
    drain();
  endtask

  initial begin
    logic [9:0] gvec;
    int         ngnt;

    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    check("reset_outputs_zero", any_output(), 0);

    // lb from the top byte lane, sign-extended.
    exp_bus(32'h1000, 4'b1000, 1'b0, 32'h0, 32'h80FF_FF11);
    exp_ls(32'hFFFF_FF80, 1'b0);
    ls_op(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0);

    // sh to the upper half: data replicated, store returns zero data.
    exp_bus(32'h2000, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'hDEAD_BEEF);
    exp_ls(32'h0, 1'b0);
    ls_op(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_BEEF);

    // Misaligned word and other faulting accesses never touch the bus.
    exp_ls(32'h0, 1'b1);
    ls_op(1'b0, 2'b10, 1'b0, 32'h3001, 32'h0);
    exp_ls(32'h0, 1'b1);
    ls_op(1'b0, 2'b01, 1'b0, 32'h0061, 32'h0);
    exp_ls(32'h0, 1'b1);
    ls_op(1'b0, 2'b11, 1'b0, 32'h0070, 32'h0);

    exp_bus(32'h0010, 4'b0001, 1'b0, 32'h0, 32'h1234_56F0);
    exp_ls(32'h0000_00F0, 1'b0);
    ls_op(1'b0, 2'b00, 1'b1, 32'h0010, 32'h0);

    exp_bus(32'h0020, 4'b1100, 1'b0, 32'h0, 32'h8001_7FFF);
    exp_ls(32'hFFFF_8001, 1'b0);
    ls_op(1'b0, 2'b01, 1'b0, 32'h0022, 32'h0);

    exp_bus(32'h0020, 4'b0011, 1'b0, 32'h0, 32'h8001_9234);
    exp_ls(32'h0000_9234, 1'b0);
    ls_op(1'b0, 2'b01, 1'b1, 32'h0020, 32'h0);

    exp_bus(32'h0040, 4'b0010, 1'b1, 32'hA5A5_A5A5, 32'h0);
    exp_ls(32'h0, 1'b0);
    ls_op(1'b1, 2'b00, 1'b0, 32'h0041, 32'h0000_00A5);

    exp_bus(32'h0050, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0);
    exp_ls(32'h0, 1'b0);
    ls_op(1'b1, 2'b10, 1'b0, 32'h0050, 32'hCAFE_F00D);

    // Fetch ignores address bits [1:0] and is always a full-word read.
    exp_bus(32'h0104, 4'b1111, 1'b0, 32'h0, 32'h0000_0013);
    exp_if(32'h0000_0013);
    if_op(32'h0000_0107);

    // Both requesters held: expected order L,L,L,L,I,L,L,L,L,I.
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) begin
        exp_bus(32'h0800, 4'b1111, 1'b0, 32'h0, 32'h2222_2222);
        exp_if(32'h2222_2222);
      end else begin
        exp_bus(32'h0400, 4'b1111, 1'b0, 32'h0, 32'h1111_1111);
        exp_ls(32'h1111_1111, 1'b0);
      end
    end
    @(posedge clk); #1;
    if_req_i = 1'b1; if_addr_i = 32'h0800;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'b10; ls_unsigned_i = 1'b0;
    ls_addr_i = 32'h0400;
    gvec = '0;
    ngnt = 0;
    for (int n = 0; n < 3000 && ngnt < 10; n++) begin
      @(negedge clk);
      if (if_gnt_o || ls_gnt_o) begin
        gvec = {gvec[8:0], if_gnt_o};
        ngnt++;
      end
    end
    @(posedge clk); #1;
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
    check("starve_grant_count", ngnt, 10);
    check("starve_grant_order", gvec, 10'b0000100001);
    drain();

    // Reset while waiting for the bus response; the late response must be dropped.
    auto_bus = 1'b0;
    @(posedge clk); #1;
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_size_i = 2'b10; ls_addr_i = 32'h0900;
    wait_gnt(1'b0, "rst_case_gnt");
    @(posedge clk); #1;
    ls_req_i = 1'b0;
    begin
      bit seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (mem_req_o) begin
          seen = 1'b1;
          break;
        end
      end
      check("rst_case_mem_req", seen, 1);
    end
    mem_gnt_i = 1'b1;
    @(negedge clk);
    mem_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    check("mid_reset_outputs_zero", any_output(), 0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = 32'h0000_0055;
    @(negedge clk);
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
    check("late_resp_dropped", any_output(), 0);
    repeat (3) @(negedge clk);
    auto_bus = 1'b1;

    // After reset the arbiter is usable again.
    exp_bus(32'h0A00, 4'b1111, 1'b0, 32'h0, 32'h0BAD_F00D);
    exp_ls(32'h0BAD_F00D, 1'b0);
    ls_op(1'b0, 2'b10, 1'b0, 32'h0A00, 32'h0);

    check("scoreboard_empty", exp_q.size(), 0);
    check("bus_queue_empty", bus_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
